// File: rtl/filter_pkg.sv
// Shared definitions for the filter datapath: tagged word layout, tag codes and sequencer states.
package filter_pkg;

   localparam int TAG_WIDTH  = 2;
   localparam int PIX_WIDTH  = 8;
   localparam int DATA_WIDTH = PIX_WIDTH + TAG_WIDTH;
   localparam int DIM_WIDTH  = 10;

   localparam logic [TAG_WIDTH-1:0] INVALID_TAG  = 2'd0;
   localparam logic [TAG_WIDTH-1:0] DATA_TAG0    = 2'd1;
   localparam logic [TAG_WIDTH-1:0] DATA_TAG1    = 2'd2;
   localparam logic [TAG_WIDTH-1:0] DATA_END_TAG = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REFRESH = 3'd1,
      ST_PRIME   = 3'd2,
      ST_STREAM  = 3'd3,
      ST_FLUSH   = 3'd4,
      ST_DONE    = 3'd5
   } ctrl_state_t;

   // Tag lives in the MSBs of every word crossing the filter boundary.
   function automatic logic [TAG_WIDTH-1:0] word_tag(input logic [DATA_WIDTH-1:0] word);
      return word[DATA_WIDTH-1 -: TAG_WIDTH];
   endfunction

endpackage

// File: rtl/filter_raster_cnt.sv
// Raster position counter: x wraps at width-1 and bumps y; flags the final position and odd lines.
module filter_raster_cnt
   import filter_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 advance,
   input  logic [DIM_WIDTH-1:0] width,
   input  logic [DIM_WIDTH-1:0] height,
   output logic                 last,
   output logic                 odd
);

   logic [DIM_WIDTH-1:0] x;
   logic [DIM_WIDTH-1:0] y;
   logic                 line_end;

   assign line_end = (x == width - DIM_WIDTH'(1));
   assign last     = line_end && (y == height - DIM_WIDTH'(1));
   assign odd      = y[0];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (last) begin
            x <= '0;
            y <= '0;
         end else if (line_end) begin
            x <= '0;
            y <= y + DIM_WIDTH'(1);
         end else begin
            x <= x + DIM_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/filter_stream_ctrl.sv
// Frame sequencer feeding filter_unit: refresh, prime, gap-free raster stream, drain, report.
// Optional FILTER_CTRL_STATS_EN adds per-frame output-count and cycle-count statistics.
module filter_stream_ctrl
   import filter_pkg::*;
#(
   parameter int OPE_WIDTH     = 3,
   parameter int FLUSH_TIMEOUT = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIM_WIDTH-1:0]  cfg_width,
   input  logic [DIM_WIDTH-1:0]  cfg_height,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [PIX_WIDTH-1:0]  src_data,
   input  logic                  src_valid,
   output logic                  src_ready,
   output logic [DATA_WIDTH-1:0] filt_data_in,
   output logic                  filt_refresh,
   output logic [DIM_WIDTH-1:0]  filt_image_width,
   input  logic [DATA_WIDTH-1:0] filt_data_out,
   output logic [PIX_WIDTH-1:0]  dst_data,
   output logic                  dst_valid,
   output logic                  dst_last,
   output logic                  err_underrun,
   output logic                  err_timeout,
   output logic                  err_cfg,
`ifdef FILTER_CTRL_STATS_EN
   output logic [19:0]           stat_out_count,
   output logic [31:0]           stat_cycles,
`endif
   output ctrl_state_t           dbg_state
);

   // Handshake: a source pixel moves when src_valid && src_ready at a rising edge;
   // src_ready is high for every STREAM cycle and the stream never waits on src_valid.

   localparam int PW = DIM_WIDTH + $clog2(OPE_WIDTH);
   localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

   ctrl_state_t           state;
   ctrl_state_t           state_next;
   logic [DIM_WIDTH-1:0]  height_q;
   logic [PW-1:0]         prime_cnt;
   logic [PW-1:0]         prime_last;
   logic [TW-1:0]         flush_cnt;
   logic                  flush_expired;
   logic                  end_seen;
   logic                  cfg_ok;
   logic                  start_accept;
   logic                  rc_last;
   logic                  rc_odd;
   logic                  out_fire;
   logic [TAG_WIDTH-1:0]  out_tag;
   logic [DATA_WIDTH-1:0] stream_word;

   assign cfg_ok        = (cfg_width >= DIM_WIDTH'(2)) && (cfg_height != '0);
   assign start_accept  = (state == ST_IDLE) && start && cfg_ok;
   assign prime_last    = PW'(filt_image_width) * PW'(OPE_WIDTH - 1) - PW'(1);
   assign flush_expired = (flush_cnt == TW'(FLUSH_TIMEOUT - 1));
   assign out_tag       = word_tag(filt_data_out);
   assign end_seen      = (out_tag == DATA_END_TAG);
   assign out_fire      = ((state == ST_STREAM) || (state == ST_FLUSH)) && (out_tag != INVALID_TAG);
   assign dbg_state     = state;

   filter_raster_cnt u_raster (
      .clk     (clk),
      .rst     (rst),
      .clear   (start_accept),
      .advance (state == ST_STREAM),
      .width   (filt_image_width),
      .height  (height_q),
      .last    (rc_last),
      .odd     (rc_odd)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (start_accept) state_next = ST_REFRESH;
         ST_REFRESH: state_next = ST_PRIME;
         ST_PRIME:   if (prime_cnt == prime_last) state_next = ST_STREAM;
         ST_STREAM:  if (rc_last) state_next = ST_FLUSH;
         ST_FLUSH:   if (end_seen || flush_expired) state_next = ST_DONE;
         ST_DONE:    state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy         = (state != ST_IDLE);
      src_ready    = (state == ST_STREAM);
      filt_refresh = (state == ST_REFRESH);
      done         = (state == ST_DONE);
   end

   // A missing pixel becomes a bubble, except at the final position where END must still go out.
   always_comb begin
      stream_word = {INVALID_TAG, PIX_WIDTH'(0)};
      if (src_valid)
         stream_word = {(rc_last ? DATA_END_TAG : (rc_odd ? DATA_TAG1 : DATA_TAG0)), src_data};
      else if (rc_last)
         stream_word = {DATA_END_TAG, PIX_WIDTH'(0)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_image_width <= '0;
         height_q         <= '0;
         prime_cnt        <= '0;
         flush_cnt        <= '0;
         filt_data_in     <= '0;
         dst_data         <= '0;
         dst_valid        <= 1'b0;
         dst_last         <= 1'b0;
         err_underrun     <= 1'b0;
         err_timeout      <= 1'b0;
         err_cfg          <= 1'b0;
      end else begin
         if (start_accept) begin
            filt_image_width <= cfg_width;
            height_q         <= cfg_height;
            err_underrun     <= 1'b0;
            err_timeout      <= 1'b0;
            err_cfg          <= 1'b0;
         end else if ((state == ST_IDLE) && start) begin
            err_cfg <= 1'b1;
         end
         prime_cnt <= (state == ST_PRIME) ? prime_cnt + PW'(1) : '0;
         flush_cnt <= (state == ST_FLUSH) ? flush_cnt + TW'(1) : '0;
         if ((state == ST_FLUSH) && !end_seen && flush_expired) err_timeout <= 1'b1;
         if ((state == ST_STREAM) && !src_valid) err_underrun <= 1'b1;
         filt_data_in <= (state == ST_STREAM) ? stream_word : '0;
         dst_valid    <= out_fire;
         dst_last     <= out_fire && end_seen;
         dst_data     <= out_fire ? filt_data_out[PIX_WIDTH-1:0] : '0;
      end
   end

`ifdef FILTER_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || start_accept) begin
         stat_out_count <= '0;
         stat_cycles    <= '0;
      end else begin
         if (state != ST_IDLE) stat_cycles    <= stat_cycles + 32'd1;
         if (out_fire)         stat_out_count <= stat_out_count + 20'd1;
      end
   end
`endif

endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Randomized scoreboard bench for filter_stream_ctrl with a fixed-latency identity filter stub.
module tb_filter_stream_ctrl;
   import filter_pkg::*;

   localparam int OPE = 3;
   localparam int TMO = 16;
   localparam int LAT = 3;

   logic                  clk;
   logic                  rst;
   logic [DIM_WIDTH-1:0]  cfg_width;
   logic [DIM_WIDTH-1:0]  cfg_height;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic [PIX_WIDTH-1:0]  src_data;
   logic                  src_valid;
   logic                  src_ready;
   logic [DATA_WIDTH-1:0] filt_data_in;
   logic                  filt_refresh;
   logic [DIM_WIDTH-1:0]  filt_image_width;
   logic [DATA_WIDTH-1:0] filt_data_out;
   logic [PIX_WIDTH-1:0]  dst_data;
   logic                  dst_valid;
   logic                  dst_last;
   logic                  err_underrun;
   logic                  err_timeout;
   logic                  err_cfg;
   ctrl_state_t           dbg_state;
`ifdef FILTER_CTRL_STATS_EN
   logic [19:0]           stat_out_count;
   logic [31:0]           stat_cycles;
`endif

   filter_stream_ctrl #(.OPE_WIDTH(OPE), .FLUSH_TIMEOUT(TMO)) dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_width        (cfg_width),
      .cfg_height       (cfg_height),
      .start            (start),
      .busy             (busy),
      .done             (done),
      .src_data         (src_data),
      .src_valid        (src_valid),
      .src_ready        (src_ready),
      .filt_data_in     (filt_data_in),
      .filt_refresh     (filt_refresh),
      .filt_image_width (filt_image_width),
      .filt_data_out    (filt_data_out),
      .dst_data         (dst_data),
      .dst_valid        (dst_valid),
      .dst_last         (dst_last),
      .err_underrun     (err_underrun),
      .err_timeout      (err_timeout),
      .err_cfg          (err_cfg),
`ifdef FILTER_CTRL_STATS_EN
      .stat_out_count   (stat_out_count),
      .stat_cycles      (stat_cycles),
`endif
      .dbg_state        (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- filter stub: identity with LAT cycles latency ----------------
   logic [DATA_WIDTH-1:0] pipe [LAT];
   logic                  no_end;

   always @(posedge clk) begin
      if (rst || filt_refresh) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= filt_data_in;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign filt_data_out = (no_end && word_tag(pipe[LAT-1]) == DATA_END_TAG) ? '0 : pipe[LAT-1];

   // ---------------- scoreboard state ----------------
   typedef struct packed {
      logic                 drop;
      logic [PIX_WIDTH-1:0] pix;
   } src_t;

   src_t                  src_q[$];
   logic [DATA_WIDTH-1:0] word_q[$];
   logic [PIX_WIDTH:0]    exp_q[$];

   int n_total, n_pass;
   int cnt_refresh, cnt_prime, cnt_stream, cnt_flush, cnt_done;
   int done_pulses, refresh_pulses, busy_cycles, accepts;
   int exp_outs, exp_drops;
   bit aborting;
   bit prev_stream;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic zero_counters();
      cnt_refresh = 0; cnt_prime = 0; cnt_stream = 0; cnt_flush = 0; cnt_done = 0;
      done_pulses = 0; refresh_pulses = 0; busy_cycles = 0; accepts = 0;
   endtask

   // ---------------- source driver ----------------
   always @(negedge clk) begin
      src_t item;
      if (aborting) begin
         src_q.delete();
         src_valid = 1'b0;
         src_data  = '0;
      end else if (src_ready && src_q.size() > 0) begin
         item      = src_q.pop_front();
         src_valid = !item.drop;
         src_data  = item.drop ? PIX_WIDTH'($urandom) : item.pix;
         if (!item.drop) accepts++;
      end else begin
         src_valid = src_ready ? 1'b0 : 1'($urandom_range(0, 1));
         src_data  = PIX_WIDTH'($urandom);
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [DATA_WIDTH-1:0] w;
      logic [PIX_WIDTH:0]    e;
      if (busy) busy_cycles++;
      if (done) done_pulses++;
      if (filt_refresh) refresh_pulses++;
      case (dbg_state)
         ST_REFRESH: cnt_refresh++;
         ST_PRIME:   cnt_prime++;
         ST_STREAM:  cnt_stream++;
         ST_FLUSH:   cnt_flush++;
         ST_DONE:    cnt_done++;
         default:    ;
      endcase
      if (aborting) begin
         exp_q.delete();
         word_q.delete();
         prev_stream = 1'b0;
      end else begin
         if (prev_stream) begin
            if (word_q.size() == 0) begin
               n_total++;
               $display("FAIL filt_data_in: got %0h with no expected word", filt_data_in);
            end else begin
               w = word_q.pop_front();
               check("filt_data_in", 32'(filt_data_in), 32'(w));
            end
         end
         if (dst_valid) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL dst_out: got last=%0b data=%0h with no expected result", dst_last, dst_data);
            end else begin
               e = exp_q.pop_front();
               check("dst_out", 32'({dst_last, dst_data}), 32'(e));
            end
         end
         prev_stream = (dbg_state == ST_STREAM);
      end
   end

   // ---------------- reference model: expected words and results for a frame ----------------
   task automatic load_frame(input int w, input int h, input int drop_pos, input int drop_pct, input bit noend);
      int n;
      logic [TAG_WIDTH-1:0]  tag;
      logic [PIX_WIDTH-1:0]  pix;
      logic [DATA_WIDTH-1:0] word;
      bit                    drop;
      bit                    last;
      n = w * h;
      exp_outs  = 0;
      exp_drops = 0;
      for (int i = 0; i < n; i++) begin
         last = (i == n - 1);
         tag  = last ? DATA_END_TAG : (((i / w) % 2 == 1) ? DATA_TAG1 : DATA_TAG0);
         pix  = PIX_WIDTH'($urandom);
         drop = (i == drop_pos) || ($urandom_range(0, 99) < drop_pct);
         if (drop) exp_drops++;
         word = drop ? {(last ? DATA_END_TAG : INVALID_TAG), 8'h00} : {tag, pix};
         src_q.push_back('{drop: drop, pix: pix});
         word_q.push_back(word);
         if (word_tag(word) != INVALID_TAG && !(noend && word_tag(word) == DATA_END_TAG)) begin
            exp_q.push_back({(word_tag(word) == DATA_END_TAG), word[PIX_WIDTH-1:0]});
            exp_outs++;
         end
      end
   endtask

   task automatic run_frame(input int w, input int h, input int drop_pos, input int drop_pct,
                            input bit noend, input bit poke);
      bit poked;
      int flush_len;
      poked = 1'b0;
      @(posedge clk); #1;
      zero_counters();
      no_end = noend;
      load_frame(w, h, drop_pos, drop_pct, noend);
      cfg_width  = DIM_WIDTH'(w);
      cfg_height = DIM_WIDTH'(h);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      cfg_width  = DIM_WIDTH'($urandom_range(0, 1023));
      cfg_height = DIM_WIDTH'($urandom_range(0, 1023));
      for (int c = 0; c < 3000 && done_pulses == 0; c++) begin
         @(posedge clk); #1;
         if (poke && !poked && dbg_state == ST_STREAM) begin
            start      = 1'b1;
            cfg_width  = 10'd1;
            cfg_height = 10'd1;
            poked      = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      flush_len = noend ? TMO : LAT + 1;
      check("done_pulses",      32'(done_pulses), 32'd1);
      check("done_state_cyc",   32'(cnt_done), 32'd1);
      check("refresh_cycles",   32'(cnt_refresh), 32'd1);
      check("refresh_pulses",   32'(refresh_pulses), 32'd1);
      check("prime_cycles",     32'(cnt_prime), 32'((OPE - 1) * w));
      check("stream_cycles",    32'(cnt_stream), 32'(w * h));
      check("src_accepts",      32'(accepts), 32'(w * h - exp_drops));
      check("flush_cycles",     32'(cnt_flush), 32'(flush_len));
      check("err_underrun",     32'(err_underrun), 32'(exp_drops > 0));
      check("err_timeout",      32'(err_timeout), 32'(noend));
      check("err_cfg",          32'(err_cfg), 32'd0);
      check("filt_image_width", 32'(filt_image_width), 32'(w));
      check("busy_after_done",  32'(busy), 32'd0);
      check("results_left",     32'(exp_q.size()), 32'd0);
      check("words_left",       32'(word_q.size()), 32'd0);
`ifdef FILTER_CTRL_STATS_EN
      check("stat_out_count",   32'(stat_out_count), 32'(exp_outs));
      check("stat_cycles",      32'(stat_cycles), 32'(2 + (OPE - 1) * w + w * h + flush_len));
`endif
   endtask

   task automatic bad_cfg(input int w, input int h);
      @(posedge clk); #1;
      zero_counters();
      cfg_width  = DIM_WIDTH'(w);
      cfg_height = DIM_WIDTH'(h);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("badcfg_err_cfg",  32'(err_cfg), 32'd1);
      check("badcfg_busy",     32'(busy_cycles), 32'd0);
      check("badcfg_refresh",  32'(refresh_pulses), 32'd0);
   endtask

   task automatic abort_frame(input int w, input int h);
      @(posedge clk); #1;
      zero_counters();
      no_end = 1'b0;
      load_frame(w, h, -1, 0, 1'b0);
      cfg_width  = DIM_WIDTH'(w);
      cfg_height = DIM_WIDTH'(h);
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 500 && cnt_stream < 5; c++) begin
         @(posedge clk); #1;
      end
      check("abort_reached_stream", 32'(cnt_stream >= 5), 32'd1);
      aborting = 1'b1;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy",         32'(busy), 32'd0);
      check("abort_src_ready",    32'(src_ready), 32'd0);
      check("abort_filt_data_in", 32'(filt_data_in), 32'd0);
      check("abort_dst_valid",    32'(dst_valid), 32'd0);
      check("abort_err_underrun", 32'(err_underrun), 32'd0);
      check("abort_image_width",  32'(filt_image_width), 32'd0);
      repeat (10) @(negedge clk);
      check("abort_no_done",      32'(done_pulses), 32'd0);
      aborting = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_total = 0; n_pass = 0;
      aborting = 1'b0; prev_stream = 1'b0; no_end = 1'b0;
      rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
      src_valid = 1'b0; src_data = '0;
      zero_counters();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy",        32'(busy), 32'd0);
      check("rst_done",        32'(done), 32'd0);
      check("rst_src_ready",   32'(src_ready), 32'd0);
      check("rst_filt_data",   32'(filt_data_in), 32'd0);
      check("rst_refresh",     32'(filt_refresh), 32'd0);
      check("rst_image_width", 32'(filt_image_width), 32'd0);
      check("rst_dst",         32'({dst_valid, dst_last, dst_data}), 32'd0);
      check("rst_errs",        32'({err_underrun, err_timeout, err_cfg}), 32'd0);

      run_frame(4, 3, -1, 0, 1'b0, 1'b0);
      run_frame(4, 3, 5, 0, 1'b0, 1'b0);
      bad_cfg(1, 3);
      bad_cfg(4, 0);
      run_frame(4, 3, -1, 0, 1'b1, 1'b0);
      abort_frame(6, 3);
      run_frame(5, 2, -1, 0, 1'b0, 1'b0);
      run_frame(4, 3, -1, 0, 1'b0, 1'b1);
      run_frame(3, 2, 5, 0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++)
         run_frame($urandom_range(2, 7), $urandom_range(1, 4), -1, 15, 1'b0, 1'($urandom_range(0, 1)));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
